// File: rtl/vc_credit_counter_if.sv
// Port bundle for vc_credit_counter: credit returns, switch grants, counter/availability view and sticky errors.
interface vc_credit_counter_if #(
    parameter int P  = 7,
    parameter int V  = 2,
    parameter int CW = 4
);
    logic [P*V-1:0]    credit_in_all;
    logic [P*V-1:0]    flit_rel_all;
    logic [P*V-1:0]    credit_out_all;
    logic [P*P-1:0]    grant_outport_all;
    logic [P*V-1:0]    grant_vc_all;
    logic [P*V-1:0]    outport_available_all;
    logic [P*V*CW-1:0] credit_count_all;
    logic [P*V-1:0]    err_overflow;
    logic [P*V-1:0]    err_underflow;
    logic [P-1:0]      err_vcsel;
    logic              err_clr;

    modport master (
        output credit_in_all, flit_rel_all, grant_outport_all, grant_vc_all, err_clr,
        input  credit_out_all, outport_available_all, credit_count_all,
               err_overflow, err_underflow, err_vcsel
    );

    modport slave (
        input  credit_in_all, flit_rel_all, grant_outport_all, grant_vc_all, err_clr,
        output credit_out_all, outport_available_all, credit_count_all,
               err_overflow, err_underflow, err_vcsel
    );
endinterface

// File: rtl/vc_credit_counter.sv
// Per outport/VC downstream credit counters with saturation, sticky error flags and registered credit return.
// Latency: counts and credit_out_all update one edge after the causing input; availability is combinational from the count.
// Backpressure: none accepted; availability is the backpressure this block offers to the switch allocator.
module vc_credit_counter #(
    parameter int P        = 7,
    parameter int V        = 2,
    parameter int DEPTH    = 8,
    parameter int AVAIL_TH = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                rst,
    vc_credit_counter_if.slave bus
);
    localparam int N = P * V;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] TH   = CW'(AVAIL_TH);

    logic [P-1:0]         gnt;
    logic [P-1:0]         vc_ok;
    logic [P-1:0]         vcsel_set;
    logic [N-1:0]         inc;
    logic [N-1:0]         dec;
    logic [N-1:0]         ovf_set;
    logic [N-1:0]         unf_set;
    logic [N-1:0][CW-1:0] cnt_q;
    logic [N-1:0][CW-1:0] cnt_d;
    logic [N-1:0]         avail;
    logic [N-1:0]         credit_out_q;
    logic [N-1:0]         ovf_q;
    logic [N-1:0]         unf_q;
    logic [P-1:0]         vcsel_q;

    function automatic logic is_onehot(input logic [V-1:0] x);
        return (x != '0) && ((x & (x - V'(1))) == '0);
    endfunction

    // Several inports granted to one outport still move only one flit.
    always_comb begin
        gnt       = '0;
        vc_ok     = '0;
        vcsel_set = '0;
        dec       = '0;
        for (int o = 0; o < P; o++) begin
            gnt[o]       = |bus.grant_outport_all[o*P +: P];
            vc_ok[o]     = is_onehot(bus.grant_vc_all[o*V +: V]);
            vcsel_set[o] = gnt[o] & ~vc_ok[o];
            for (int v = 0; v < V; v++) begin
                dec[o*V+v] = gnt[o] & vc_ok[o] & bus.grant_vc_all[o*V+v];
            end
        end
    end

    assign inc = bus.credit_in_all;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = '0;
        unf_set = '0;
        for (int k = 0; k < N; k++) begin
            if (inc[k] && !dec[k]) begin
                if (cnt_q[k] == FULL) ovf_set[k] = 1'b1;
                else                  cnt_d[k]   = cnt_q[k] + CW'(1);
            end else if (dec[k] && !inc[k]) begin
                if (cnt_q[k] == '0)   unf_set[k] = 1'b1;
                else                  cnt_d[k]   = cnt_q[k] - CW'(1);
            end
        end
    end

    // A new error in the same cycle as err_clr must survive the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) cnt_q[k] <= FULL;
            credit_out_q <= '0;
            ovf_q        <= '0;
            unf_q        <= '0;
            vcsel_q      <= '0;
        end else begin
            cnt_q        <= cnt_d;
            credit_out_q <= bus.flit_rel_all;
            ovf_q        <= (ovf_q   & {N{~bus.err_clr}}) | ovf_set;
            unf_q        <= (unf_q   & {N{~bus.err_clr}}) | unf_set;
            vcsel_q      <= (vcsel_q & {P{~bus.err_clr}}) | vcsel_set;
        end
    end

    always_comb begin
        avail = '0;
        for (int k = 0; k < N; k++) avail[k] = (cnt_q[k] >= TH);
    end

    assign bus.credit_out_all        = credit_out_q;
    assign bus.outport_available_all = avail;
    assign bus.credit_count_all      = cnt_q;
    assign bus.err_overflow          = ovf_q;
    assign bus.err_underflow         = unf_q;
    assign bus.err_vcsel             = vcsel_q;
endmodule
